// File: rtl/tag_anc_pkg.sv
// ============================================================================
// Module      : tag_anc_pkg
// Description : Shared state encodings and GPIO defaults for the tag RX
//               sequencing logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_anc_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t c_st_init = 2'b00;
    localparam rx_state_t c_st_sync = 2'b01;
    localparam rx_state_t c_st_rx   = 2'b11;

    localparam int c_sync_gpio_bit_def  = 0;
    localparam int c_thres_gpio_bit_def = 4;

    // Output-enable mask with exactly the two given bit positions set.
    function automatic logic [31:0] gpio_bit_mask(input int bit_a, input int bit_b);
        return (32'd1 << bit_a) | (32'd1 << bit_b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tag_sync_gen.sv
// ============================================================================
// Module      : tag_sync_gen
// Description : Sync-burst sample counter with polarity and rx_trig decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_sync_gen #(
    parameter int CNT_WIDTH  = 16,
    parameter int TRIG_DELAY = 960
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 active,
    input  logic [CNT_WIDTH-1:0] nsyncp,
    input  logic [CNT_WIDTH-1:0] nsyncn,
    output logic [CNT_WIDTH:0]   count,
    output logic                 positive,
    output logic                 rx_trig,
    output logic                 last,
    output logic                 empty
);

    localparam logic [CNT_WIDTH+1:0] c_trig_delay = (CNT_WIDTH+2)'(TRIG_DELAY);

    logic [CNT_WIDTH-1:0] r_nsyncp;
    logic [CNT_WIDTH-1:0] r_nsyncn;
    logic [CNT_WIDTH:0]   r_count;
    logic [CNT_WIDTH:0]   w_total;
    logic [CNT_WIDTH+1:0] w_total_x;

    // Lengths are captured only on entry to a burst so that mid-burst
    // changes of the runtime inputs cannot reshape the waveform.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nsyncp <= '0;
            r_nsyncn <= '0;
            r_count  <= '0;
        end else begin
            if (load) begin
                r_nsyncp <= nsyncp;
                r_nsyncn <= nsyncn;
            end
            if (clear || load) begin
                r_count <= '0;
            end else if (advance) begin
                r_count <= r_count + (CNT_WIDTH+1)'(1);
            end
        end
    end

    assign w_total   = {1'b0, r_nsyncp} + {1'b0, r_nsyncn};
    assign w_total_x = {1'b0, w_total};

    assign count    = r_count;
    assign empty    = (w_total == '0);
    assign last     = !empty && (r_count == w_total - (CNT_WIDTH+1)'(1));
    assign positive = (r_count < {1'b0, r_nsyncp});
    assign rx_trig  = active && (w_total_x > c_trig_delay) &&
                      ({1'b0, r_count} < (w_total_x - c_trig_delay));

endmodule

`default_nettype wire

// File: rtl/tag_rx_seq_ctrl.sv
// ============================================================================
// Module      : tag_rx_seq_ctrl
// Description : Sequences sync-burst insertion and RX windows after preamble
//               detection; injects the sync waveform into the sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_rx_seq_ctrl
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NCHAN          = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int TMO_WIDTH      = 24,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_AMP       = 16384,
    parameter int TRIG_DELAY     = 960,
    parameter int SYNC_GPIO_BIT  = c_sync_gpio_bit_def,
    parameter int THRES_GPIO_BIT = c_thres_gpio_bit_def
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run_rx,
    input  logic [CNT_WIDTH-1:0]          nsyncp,
    input  logic [CNT_WIDTH-1:0]          nsyncn,
    input  logic [3:0]                    nrounds,
    input  logic [TMO_WIDTH-1:0]          rx_timeout,
    input  logic [DATA_WIDTH-1:0]         scale_val,
    input  logic                          s_tvalid,
    input  logic [NCHAN*2*DATA_WIDTH-1:0] s_tdata,
    input  logic                          peak_tvalid,
    input  logic                          peak_stb,
    input  logic                          peak_thres,
    input  logic                          rx_sync_ready,
    output logic                          m_tvalid,
    output logic [NCHAN*2*DATA_WIDTH-1:0] m_tdata,
    output logic                          rx_valid,
    output logic                          rx_trig,
    output logic [DATA_WIDTH-1:0]         scale_out,
    output logic                          timeout_stb,
    output logic [GPIO_REG_WIDTH-1:0]     fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0]     fp_gpio_ddr,
    output logic [1:0]                    rx_state,
    output logic [CNT_WIDTH:0]            sync_count
);

    localparam logic [DATA_WIDTH-1:0]     c_amp_pos  = DATA_WIDTH'(SYNC_AMP);
    localparam logic [DATA_WIDTH-1:0]     c_amp_neg  = DATA_WIDTH'(-SYNC_AMP);
    localparam logic [DATA_WIDTH-1:0]     c_scale_1  = DATA_WIDTH'(1);
    localparam logic [GPIO_REG_WIDTH-1:0] c_gpio_ddr =
        GPIO_REG_WIDTH'(gpio_bit_mask(SYNC_GPIO_BIT, THRES_GPIO_BIT));

    logic [1:0]                    r_state;
    logic [3:0]                    r_rounds_left;
    logic [TMO_WIDTH-1:0]          r_tmo_cnt;
    logic                          r_rx_valid;
    logic                          r_timeout_stb;
    logic [DATA_WIDTH-1:0]         r_scale;
    logic                          r_m_tvalid;
    logic [NCHAN*2*DATA_WIDTH-1:0] r_m_tdata;
    logic [GPIO_REG_WIDTH-1:0]     r_gpio;

    logic [1:0]                    w_next_state;
    logic                          w_load;
    logic                          w_enter_rx;
    logic                          w_timeout;
    logic                          w_in_sync;
    logic                          w_positive;
    logic                          w_sync_last;
    logic                          w_sync_empty;
    logic                          w_rx_trig;
    logic [CNT_WIDTH:0]            w_count;
    logic [TMO_WIDTH:0]            w_tmo_inc;
    logic [NCHAN*2*DATA_WIDTH-1:0] w_sync_word;
    logic [GPIO_REG_WIDTH-1:0]     w_gpio;

    assign w_in_sync = run_rx && (r_state == c_st_sync);
    assign w_tmo_inc = {1'b0, r_tmo_cnt} + (TMO_WIDTH+1)'(1);

    tag_sync_gen #(
        .CNT_WIDTH  (CNT_WIDTH),
        .TRIG_DELAY (TRIG_DELAY)
    ) u_sync_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (!run_rx),
        .load     (w_load),
        .advance  (w_in_sync && s_tvalid),
        .active   (w_in_sync),
        .nsyncp   (nsyncp),
        .nsyncn   (nsyncn),
        .count    (w_count),
        .positive (w_positive),
        .rx_trig  (w_rx_trig),
        .last     (w_sync_last),
        .empty    (w_sync_empty)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_enter_rx   = 1'b0;
        w_timeout    = 1'b0;
        if (!run_rx) begin
            w_next_state = c_st_init;
        end else begin
            case (r_state)
                c_st_init: begin
                    if (peak_tvalid && peak_stb) begin
                        w_next_state = c_st_sync;
                        w_load       = 1'b1;
                    end
                end
                c_st_sync: begin
                    if (w_sync_empty || (s_tvalid && w_sync_last)) begin
                        w_next_state = c_st_rx;
                        w_enter_rx   = 1'b1;
                    end
                end
                c_st_rx: begin
                    // A symbol-boundary exit takes priority over the timeout.
                    if (rx_sync_ready && peak_tvalid) begin
                        if (r_rounds_left != 4'd0) begin
                            w_next_state = c_st_sync;
                            w_load       = 1'b1;
                        end else begin
                            w_next_state = c_st_init;
                        end
                    end else if ((rx_timeout != '0) && s_tvalid &&
                                 (w_tmo_inc >= {1'b0, rx_timeout})) begin
                        w_next_state = c_st_init;
                        w_timeout    = 1'b1;
                    end
                end
                default: w_next_state = c_st_init;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_init;
            r_rounds_left <= '0;
            r_tmo_cnt     <= '0;
            r_rx_valid    <= 1'b0;
            r_timeout_stb <= 1'b0;
            r_scale       <= c_scale_1;
        end else begin
            r_state       <= w_next_state;
            r_timeout_stb <= w_timeout;
            if (!run_rx) begin
                r_rounds_left <= '0;
                r_tmo_cnt     <= '0;
                r_rx_valid    <= 1'b0;
                r_scale       <= c_scale_1;
            end else begin
                case (r_state)
                    c_st_init: begin
                        r_scale <= (scale_val == '0) ? c_scale_1 : scale_val;
                        if (peak_tvalid) begin
                            r_rx_valid <= peak_stb;
                        end
                        if (w_load) begin
                            r_rounds_left <= (nrounds == 4'd0) ? 4'd0 : nrounds - 4'd1;
                        end
                    end
                    c_st_sync: begin
                        if (w_enter_rx) begin
                            r_tmo_cnt <= '0;
                        end
                    end
                    c_st_rx: begin
                        if (w_load) begin
                            r_rounds_left <= r_rounds_left - 4'd1;
                        end
                        if (s_tvalid) begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_WIDTH'(1);
                        end
                        if (w_timeout) begin
                            r_rx_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Each channel carries {I,Q} with Q in the low half.
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        assign w_sync_word[c*2*DATA_WIDTH +: DATA_WIDTH] = '0;
        assign w_sync_word[c*2*DATA_WIDTH+DATA_WIDTH +: DATA_WIDTH] =
            w_positive ? c_amp_pos : c_amp_neg;
    end

    always_comb begin
        w_gpio                 = '0;
        w_gpio[SYNC_GPIO_BIT]  = (r_state == c_st_sync);
        w_gpio[THRES_GPIO_BIT] = peak_thres;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_gpio     <= '0;
        end else begin
            r_m_tvalid <= s_tvalid;
            r_m_tdata  <= w_in_sync ? w_sync_word : s_tdata;
            r_gpio     <= w_gpio;
        end
    end

    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_m_tdata;
    assign rx_valid    = r_rx_valid;
    assign rx_trig     = w_rx_trig;
    assign scale_out   = r_scale;
    assign timeout_stb = r_timeout_stb;
    assign fp_gpio_out = r_gpio;
    assign fp_gpio_ddr = c_gpio_ddr;
    assign rx_state    = r_state;
    assign sync_count  = w_count;

endmodule

`default_nettype wire

// File: doc/tag_rx_seq_ctrl.md
TAG_RX_SEQ_CTRL -- requirements
Module: tag_rx_seq_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 16, sample component width; NCHAN, 2, RX channels; CNT_WIDTH, 16, sync-length counter width; TMO_WIDTH, 24, RX timeout counter width; GPIO_REG_WIDTH, 12, GPIO width; SYNC_AMP, 16384, sync I amplitude; TRIG_DELAY, 960, rx_trig lead in samples; SYNC_GPIO_BIT, 0; THRES_GPIO_BIT, 4.
REQ-002 SHALL have ports: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset; run_rx in 1, enable; nsyncp in CNT_WIDTH, positive sync length; nsyncn in CNT_WIDTH, negative sync length; nrounds in 4, sync/RX rounds per detection; rx_timeout in TMO_WIDTH, RX wait limit in samples (0 = none); scale_val in DATA_WIDTH, requested scale.
REQ-003 SHALL have ports: s_tvalid in 1, sample strobe; s_tdata in NCHAN*2*DATA_WIDTH, per-channel {I,Q}, channel 0 in LSBs; peak_tvalid in 1, peak_stb in 1, peak_thres in 1, preamble detector outputs; rx_sync_ready in 1, demod symbol-boundary flag.
REQ-004 SHALL have ports: m_tvalid out 1; m_tdata out NCHAN*2*DATA_WIDTH; rx_valid out 1; rx_trig out 1; scale_out out DATA_WIDTH; timeout_stb out 1; fp_gpio_out out GPIO_REG_WIDTH; fp_gpio_ddr out GPIO_REG_WIDTH; rx_state out 2; sync_count out CNT_WIDTH+1.

Function
REQ-005 SHALL implement states INIT=2'b00, SYNC=2'b01, RX=2'b11; rx_state SHALL equal current state.
REQ-006 SHALL, when run_rx=0, synchronously force INIT, zero all counters, deassert rx_valid/rx_trig/timeout_stb, scale_out=1.
REQ-007 INIT: on peak_tvalid&peak_stb -> SYNC, rx_valid<=1, count<=0, rounds_left<=max(nrounds,1)-1; on peak_tvalid&~peak_stb rx_valid<=0; each cycle scale_out<=(scale_val==0)?1:scale_val.
REQ-008 SYNC: count SHALL increment only on s_tvalid; total=nsyncp+nsyncn computed at CNT_WIDTH+1 bits, no overflow.
REQ-009 SYNC: rx_trig SHALL be 1 while count < total-TRIG_DELAY, else 0; if TRIG_DELAY>=total rx_trig SHALL stay 0.
REQ-010 SYNC: on s_tvalid with count==total-1 -> RX, timeout counter<=0; total==0 SHALL go to RX on the next cycle.
REQ-011 RX: rx_sync_ready&peak_tvalid with rounds_left>0 -> SYNC, count<=0, rounds_left decrements; with rounds_left==0 -> INIT.
REQ-012 RX: timeout counter increments per s_tvalid; reaching rx_timeout (nonzero) before exit -> INIT with one-cycle timeout_stb=1 and rx_valid<=0; exit condition wins over timeout in the same cycle.
REQ-013 m_tdata SHALL be registered, latency 1 from s_tdata/s_tvalid; m_tvalid=s_tvalid delayed 1.
REQ-014 In SYNC every channel I SHALL be +SYNC_AMP when count<nsyncp else -SYNC_AMP (two's complement), Q=0; otherwise m_tdata=s_tdata.
REQ-015 No backpressure: every s_tvalid sample SHALL appear on m_tvalid exactly once.
REQ-016 fp_gpio_out SHALL be registered: bit SYNC_GPIO_BIT=(state==SYNC), bit THRES_GPIO_BIT=peak_thres, others 0; fp_gpio_ddr constant with only those two bits set.
REQ-017 Runtime inputs nsyncp/nsyncn SHALL be sampled at INIT->SYNC and RX->SYNC transitions; changes mid-SYNC SHALL have no effect.

Reset
REQ-018 reset_n low SHALL asynchronously set: state INIT, all counters 0, rx_valid 0, rx_trig 0, timeout_stb 0, m_tvalid 0, m_tdata 0, fp_gpio_out 0, scale_out 1.
REQ-019 Deassertion SHALL be synchronized externally; first operation on first clk after release.

Structure
REQ-020 State encodings and GPIO bit defaults SHALL live in shared package tag_anc_pkg.
REQ-021 A sub-module tag_sync_gen (counter, polarity, rx_trig) is the natural split; FSM stays in top.

Verification
REQ-022 nsyncp=8, nsyncn=8, TRIG_DELAY=4, peak_stb pulse, s_tvalid=1 -> I=+16384 x8, -16384 x8, Q=0, rx_trig high 12 samples, RX after 16.
REQ-023 nrounds=3, rx_sync_ready&peak_tvalid each RX -> three SYNC bursts then INIT without new peak.
REQ-024 rx_timeout=100, no rx_sync_ready -> INIT after 100 samples, timeout_stb single-cycle, rx_valid=0.
REQ-025 run_rx dropped mid-SYNC at count 5 -> INIT next cycle, outputs pass-through, scale_out=1.
REQ-026 reset_n asserted between edges -> outputs at reset values immediately; scale_val=0 in INIT -> scale_out=1.
REQ-027 s_tvalid 50% duty in SYNC -> count advances only on valid; waveform length 16 valid samples.
